// File: rtl/pmod_spi_arb_pkg.sv
// Shared types and constants for the PMOD SPI arbiter: FSM states, pin map,
// and the round-robin pick used at grant time.
package pmod_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int PIN_CS   = 0;
    localparam int PIN_MOSI = 1;
    localparam int PIN_MISO = 2;
    localparam int PIN_SCLK = 3;

    localparam logic [3:0] PIN_OE_SPI = 4'b1011;

    // last = index of the requester served most recently; on a tie the other one wins.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
        if (req == 2'b11) begin
            return last ? 2'b01 : 2'b10;
        end
        return req;
    endfunction

endpackage

// File: rtl/pmod_spi_shift.sv
// Mode-0 data path: MSB-first transmit register, LSB-in receive register,
// and the bit counter that marks the final bit of a frame.
module pmod_spi_shift #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [DW-1:0] tx,
    input  logic          shift_out,
    input  logic          sample,
    input  logic          miso,
    output logic          mosi,
    output logic [DW-1:0] rx,
    output logic          last_bit
);

    localparam int CW = $clog2(DW);

    logic [DW-1:0] tx_sr;
    logic [DW-1:0] rx_sr;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sr <= '0;
            rx_sr <= '0;
            cnt   <= '0;
        end else if (load) begin
            tx_sr <= tx;
            rx_sr <= '0;
            cnt   <= CW'(DW - 1);
        end else begin
            if (shift_out) begin
                tx_sr <= {tx_sr[DW-2:0], 1'b0};
                cnt   <= cnt - 1'b1;
            end
            if (sample) begin
                rx_sr <= {rx_sr[DW-2:0], miso};
            end
        end
    end

    assign mosi     = tx_sr[DW-1];
    assign rx       = rx_sr;
    assign last_bit = (cnt == '0);

endmodule

// File: rtl/pmod_spi_arb.sv
// Two-requester round-robin SPI master (mode 0) driving PMOD pins 1-4,
// with per-pin output enables that tri-state the row when disabled.
module pmod_spi_arb
    import pmod_pkg::*;
#(
    parameter int DW   = 8,
    parameter int HALF = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [1:0]    req,
    input  logic [DW-1:0] tx_data0,
    input  logic [DW-1:0] tx_data1,
    output logic [1:0]    gnt,
    output logic [1:0]    done,
    output logic [DW-1:0] rx_data,
    output logic          busy,
    output logic          cs_n,
    output logic          mosi,
    input  logic          miso,
    output logic          sclk,
    output logic [3:0]    pin_oe,
    output state_t        dbg_state
);

    localparam int HW = (HALF > 1) ? $clog2(HALF) : 1;

    state_t        state;
    logic [HW-1:0] hcnt;
    logic          last;
    logic          half_end;
    logic          grant_now;
    logic [1:0]    win;
    logic          load;
    logic          shift_out;
    logic          sample;
    logic          last_bit;
    logic [DW-1:0] tx_sel;
    logic [DW-1:0] rx;

    // Handshake: a requester holds req until its done pulse; gnt marks the owner
    // from SETUP through DONE, and done is a single-cycle strobe with rx_data valid.
    always_comb begin
        half_end  = (hcnt == HW'(HALF - 1));
        win       = rr_pick(req, last);
        grant_now = (state == IDLE) && en && (req != 2'b00);
        load      = grant_now;
        tx_sel    = win[1] ? tx_data1 : tx_data0;
        // sample on the rising sclk edge, present the next bit on the falling one
        sample    = (state == SHIFT) && half_end && !sclk;
        shift_out = (state == SHIFT) && half_end && sclk && !last_bit;
    end

    pmod_spi_shift #(.DW(DW)) u_shift (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .tx        (tx_sel),
        .shift_out (shift_out),
        .sample    (sample),
        .miso      (miso),
        .mosi      (mosi),
        .rx        (rx),
        .last_bit  (last_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            hcnt    <= '0;
            last    <= 1'b1;
            gnt     <= 2'b00;
            done    <= 2'b00;
            rx_data <= '0;
            busy    <= 1'b0;
            cs_n    <= 1'b1;
            sclk    <= 1'b0;
        end else begin
            done <= 2'b00;
            case (state)
                IDLE: begin
                    if (grant_now) begin
                        state <= SETUP;
                        gnt   <= win;
                        last  <= win[1];
                        busy  <= 1'b1;
                        cs_n  <= 1'b0;
                        hcnt  <= '0;
                    end
                end
                SETUP: begin
                    if (half_end) begin
                        state <= SHIFT;
                        hcnt  <= '0;
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (half_end) begin
                        hcnt <= '0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else begin
                            sclk <= 1'b0;
                            if (last_bit) begin
                                state <= HOLD;
                            end
                        end
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (half_end) begin
                        state   <= DONE;
                        hcnt    <= '0;
                        cs_n    <= 1'b1;
                        done    <= gnt;
                        rx_data <= rx;
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    gnt   <= 2'b00;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Enables drop the instant en falls; sequencing keeps running internally.
    assign pin_oe    = (en && rst_n) ? PIN_OE_SPI : 4'b0000;
    assign dbg_state = state;

endmodule

// File: doc/pmod_spi_arb.md
Name: pmod_spi_arb

Overview:
Two-requester SPI master that owns the 4-pin PMOD row (pins 1-4) and sequences serial transactions on it. Requesters are arbitrated round-robin. The winner's word is shifted out in SPI mode 0 while the reply is captured. The block drives per-pin output enables so the pin-level bidirectional buffers tri-state when the block is disabled.

Parameters:
DW, 8, bits per transaction (2..32)
HALF, 2, clk cycles per SCLK half-period (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  port enable; low = pins tri-stated, no new grants
req  in  2  request per requester; hold high until own done
tx_data0  in  DW  word from requester 0, sampled in grant cycle
tx_data1  in  DW  word from requester 1, sampled in grant cycle
gnt  out  2  one-hot owner, high from SETUP through DONE
done  out  2  one-cycle pulse to owner at end of transaction
rx_data  out  DW  captured MISO word; valid with done, held until next done
busy  out  1  state != IDLE
cs_n  out  1  chip select to pin 1 (pmod_4321[0])
mosi  out  1  data to pin 2 (pmod_4321[1])
miso  in  1  data from pin 3 (pmod_4321[2]); always input
sclk  out  1  serial clock to pin 4 (pmod_4321[3])
pin_oe  out  4  output enable per pin; 4'b1011 when en, else 4'b0000

Behaviour:
- Reset values (async, rst_n low):
  - state IDLE; gnt 0; done 0; rx_data 0; busy 0.
  - cs_n 1; sclk 0; mosi 0; pin_oe 0.
  - last-served pointer = 1, so requester 0 wins the first tie.
- Arbitration, IDLE only:
  - Grant only if en=1 and req!=0.
  - Single request: grant it.
  - Both requesting: grant the requester not last served; the pointer updates at grant.
  - Grant cycle: the owner's tx word is latched MSB-first into the shift register, and the next state is SETUP.
- SETUP, HALF cycles:
  - cs_n=0, sclk=0, mosi=tx[DW-1].
- SHIFT, 2*DW*HALF cycles, one bit = low half then high half:
  - On entry to each high half, sclk rises and miso is sampled into rx[LSB], shifting left.
  - On entry to each following low half, sclk falls and mosi presents the next bit.
  - The bit counter runs DW-1 down to 0; SHIFT ends after the high half of bit 0.
- HOLD, HALF cycles:
  - sclk=0, cs_n=0, mosi held.
- DONE, 1 cycle:
  - cs_n=1; done[owner]=1; rx_data updated; gnt still asserted.
  - Next state IDLE.
- Latency: req seen in IDLE at cycle 0 gives done at cycle 1+(2*DW+2)*HALF. For the defaults that is cycle 37.
- Back-to-back: at least 1 IDLE cycle with cs_n=1 between transactions, so a continuously requesting owner alternates fairly with the other.
- req dropped mid-transaction: ignored; the transaction completes and done is still pulsed.
- en dropped mid-transaction: the transaction completes. pin_oe follows en combinationally, so the pins tri-state immediately while internal sequencing finishes. No grant occurs while en=0.
- rst_n asserted mid-transaction: immediate return to reset values, no done pulse, rx_data cleared.
- HALF counter and bit counter widths are $clog2-sized and may not wrap within a phase.

Decomposition:
- Package pmod_pkg:
  - State enum {IDLE, SETUP, SHIFT, HOLD, DONE}.
  - Pin index constants PIN_CS=0, PIN_MOSI=1, PIN_MISO=2, PIN_SCLK=3.
  - PIN_OE_SPI=4'b1011.
- Sub-module pmod_spi_shift: DW-bit shift register plus bit counter. Inputs load/tx, shift_out, sample/miso; outputs mosi, rx, last_bit. The top holds the arbiter, FSM and half-period counter.

Test Plan:
- Reset: rst_n=0 then release with en=1 and req=0 -> cs_n=1, sclk=0, pin_oe=4'b1011, busy=0, gnt=0.
- Single transfer: req=2'b01, tx_data0=8'hA5, MISO slave returns 8'h3C.
  - mosi bits on sclk rising edges = 1,0,1,0,0,1,0,1.
  - 8 sclk rising edges.
  - done[0] at cycle 37; rx_data=8'h3C.
- Tie and fairness: req=2'b11 held for 3 transactions, tx_data0=8'h11, tx_data1=8'h22.
  - Grant order 0,1,0; each done pulses only for the matching owner.
  - cs_n high for >=1 cycle between frames.
- Abort: rst_n pulsed low at cycle 15 of a transfer -> all outputs at reset values at once, no done; a new request afterwards completes normally.
- Disable: en=0 with req=2'b10 -> no grant, pin_oe=0. Drop en mid-frame -> pin_oe=0 at once; frame still ends with done[1] at cycle 37.
- Parameters: DW=16, HALF=1, tx=16'hBEEF, loopback miso=mosi -> done at cycle 35, rx_data=16'hBEEF.
